// File: rtl/ddr_phy_dly_pkg.sv
// Shared types and constants for the per-lane IOD delay-line sequencer.
package ddr_phy_dly_pkg;

    localparam int TAP_W_DEFAULT = 8;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LGAP,
        ST_SETUP,
        ST_MOVE,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } dly_state_e;

endpackage

// File: rtl/iod_delay_line_ctrl.sv
// Steps one lane's IOD delay line to a requested tap with spaced single-tap
// MOVE/LOAD pulses, tracking the current tap and flagging out-of-range aborts.
module iod_delay_line_ctrl
    import ddr_phy_dly_pkg::*;
#(
    parameter int TAP_W    = TAP_W_DEFAULT,
    parameter int INIT_TAP = 1,
    parameter int MAX_TAP  = 255,
    parameter int MOVE_GAP = 4
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_LOAD,
    input  logic [TAP_W-1:0] REQ_TAP,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             CUR_TAP_VALID,
    output logic             DONE,
    output logic             ERR,
    output logic             ERR_STICKY
);

    localparam int               GAP_W      = 4;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MOVE_GAP - 1);
    localparam logic [TAP_W-1:0] INIT_TAP_V = TAP_W'(INIT_TAP);
    // One extra bit so the range check stays meaningful when MAX_TAP is the counter maximum.
    localparam logic [TAP_W:0]   MAX_TAP_V  = (TAP_W + 1)'(MAX_TAP);

    dly_state_e       state_q, state_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
    logic             tap_valid_q, tap_valid_d;
    logic             dir_q, dir_d;
    logic             sticky_q, sticky_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             gap_last;

    assign gap_last = (gap_cnt_q == '0);

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            cur_tap_q   <= INIT_TAP_V;
            tap_valid_q <= 1'b0;
            dir_q       <= DIR_DEC;
            sticky_q    <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cur_tap_q   <= cur_tap_d;
            tap_valid_q <= tap_valid_d;
            dir_q       <= dir_d;
            sticky_q    <= sticky_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cur_tap_d   = cur_tap_q;
        tap_valid_d = tap_valid_q;
        dir_d       = dir_q;
        sticky_d    = sticky_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    target_d = REQ_TAP;
                    sticky_d = 1'b0;
                    if ({1'b0, REQ_TAP} > MAX_TAP_V) begin
                        state_d = ST_ERR;
                    end else if (REQ_LOAD || !tap_valid_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_LOAD: begin
                cur_tap_d   = INIT_TAP_V;
                tap_valid_d = 1'b1;
                gap_cnt_d   = GAP_RELOAD;
                state_d     = ST_LGAP;
            end
            ST_LGAP: begin
                if (gap_last) begin
                    state_d = DELAY_LINE_OUT_OF_RANGE ? ST_ERR : ST_SETUP;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_SETUP: begin
                dir_d   = (target_q > cur_tap_q) ? DIR_INC : DIR_DEC;
                state_d = (target_q == cur_tap_q) ? ST_DONE : ST_MOVE;
            end
            ST_MOVE: begin
                cur_tap_d = (dir_q == DIR_INC) ? cur_tap_q + 1'b1 : cur_tap_q - 1'b1;
                gap_cnt_d = GAP_RELOAD;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_last) begin
                    // The IOD refused the last step, so the tracked tap rolls back with it.
                    if (DELAY_LINE_OUT_OF_RANGE) begin
                        cur_tap_d = (dir_q == DIR_INC) ? cur_tap_q - 1'b1 : cur_tap_q + 1'b1;
                        state_d   = ST_ERR;
                    end else if (target_q == cur_tap_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                sticky_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign REQ_READY            = (state_q == ST_IDLE);
    assign DELAY_LINE_MOVE      = (state_q == ST_MOVE);
    assign DELAY_LINE_LOAD      = (state_q == ST_LOAD);
    assign DELAY_LINE_DIRECTION = dir_q;
    assign CUR_TAP              = cur_tap_q;
    assign CUR_TAP_VALID        = tap_valid_q;
    assign DONE                 = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign ERR                  = (state_q == ST_ERR);
    assign ERR_STICKY           = sticky_q;

endmodule
